des_round_engine: RTL

Iterative Feistel round engine for the DES/3DES datapath. It sits directly downstream of the initial-permutation stage: it takes the L/R halves, applies 16 rounds at one round per clock using an external f-function and key schedule, and presents the pre-output block R16‖L16 to the final-permutation stage. With `TDES_EN` it chains three passes (EDE) internally, with no IP/FP between passes.

---
 rtl/des_round_engine.sv | 138 +++++++++++++
 1 files changed

// File: rtl/des_round_engine.sv
// des_round_engine
//
// Iterative Feistel round engine for the DES/3DES datapath, one round per clock.
// Sits between the IP stage and the FP stage; the f-function and key schedule are
// external and combinational (f_out is f(f_r, K[sk_idx]) in the same cycle).
//
// Optional feature: define TDES_EN to chain three passes (EDE / DED) internally,
// without IP/FP between passes.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   start    in   load request, sampled only in IDLE
//   decrypt  in   0 = encrypt, 1 = decrypt, sampled with start
//   L_in     in   [1:32]  left half from IP stage
//   R_in     in   [33:64] right half from IP stage
//   f_r      out  [1:32]  current R register, to the f-function
//   f_out    in   [1:32]  f-function result for f_r and the selected subkey
//   sk_idx   out  [3:0]   subkey index 1..16, 0 in IDLE; 4 bits, so subkey 16
//                         shows as 0 while busy is high
//   sk_sel   out  [1:0]   key set (K1=0, K2=1, K3=2); constant 0 without TDES_EN
//   busy     out  high while rounds are in progress
//   done     out  one-cycle pulse when pre_out is valid
//   pre_out  out  [1:64]  {R16, L16}, registered and held until the next completion
module des_round_engine #(
    // Rounds per DES pass; fixed by the standard, rnd/sk_idx widths assume 16.
    parameter int unsigned ROUNDS = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         decrypt,
    input  logic [1:32]  L_in,
    input  logic [33:64] R_in,
    output logic [1:32]  f_r,
    input  logic [1:32]  f_out,
    output logic [3:0]   sk_idx,
    output logic [1:0]   sk_sel,
    output logic         busy,
    output logic         done,
    output logic [1:64]  pre_out
);

    typedef enum logic [0:0] {StIdle, StRound} state_e;

    state_e      state_q;
    logic [1:32] l_q;
    logic [1:32] r_q;
    logic [4:0]  rnd_q;
    logic        dec_q;
`ifdef TDES_EN
    logic [1:0]  pass_q;
`endif

    logic        dir;        // direction of the current pass, 1 = decrypt
    logic        last_pass;

    always_comb begin
`ifdef TDES_EN
        // EDE for encrypt, DED for decrypt; key sets run K1,K2,K3 or K3,K2,K1.
        dir       = dec_q ^ pass_q[0];
        sk_sel    = dec_q ? (2'd2 - pass_q) : pass_q;
        last_pass = (pass_q == 2'd2);
`else
        dir       = dec_q;
        sk_sel    = 2'd0;
        last_pass = 1'b1;
`endif
        if (state_q == StIdle) begin
            sk_idx = 4'd0;
        end else if (dir) begin
            // 17 - rnd, modulo 16
            sk_idx = 4'd1 - rnd_q[3:0];
        end else begin
            sk_idx = rnd_q[3:0];
        end
    end

    assign f_r = r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            l_q     <= '0;
            r_q     <= '0;
            rnd_q   <= '0;
            dec_q   <= 1'b0;
`ifdef TDES_EN
            pass_q  <= '0;
`endif
            busy    <= 1'b0;
            done    <= 1'b0;
            pre_out <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        l_q     <= L_in;
                        r_q     <= R_in;
                        rnd_q   <= 5'd1;
                        dec_q   <= decrypt;
`ifdef TDES_EN
                        pass_q  <= 2'd0;
`endif
                        busy    <= 1'b1;
                        state_q <= StRound;
                    end
                end
                StRound: begin
                    if (rnd_q == 5'(ROUNDS)) begin
                        if (last_pass) begin
                            // Final round leaves the halves unswapped: {R16, L16}.
                            pre_out <= {l_q ^ f_out, r_q};
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            state_q <= StIdle;
                        end
`ifdef TDES_EN
                        else begin
                            // Round plus swap: equivalent to FP then IP between passes.
                            l_q    <= l_q ^ f_out;
                            rnd_q  <= 5'd1;
                            pass_q <= pass_q + 2'd1;
                        end
`endif
                    end else begin
                        l_q   <= r_q;
                        r_q   <= l_q ^ f_out;
                        rnd_q <= rnd_q + 5'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
